// File: rtl/ndn_data_ingress.sv
// NDN data-packet ingress: parses length/prefix header, buffers the payload,
// announces the packet to the FIB and streams the payload out byte by byte.
module ndn_data_ingress #(
    parameter int PAYLOAD_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic [63:0] data_in_prefix,
    output logic [5:0]  data_in_len,
    output logic        data_ready,
    output logic [7:0]  data_in,
    input  logic        pay_advance,
    input  logic        pkt_drop,
    output logic        pay_last,
    output logic [7:0]  err_count
);
    localparam int AW = $clog2(PAYLOAD_BYTES);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_BYTES - 1);

    localparam logic [2:0] RX_LEN     = 3'd0;
    localparam logic [2:0] RX_PREFIX  = 3'd1;
    localparam logic [2:0] RX_PAYLOAD = 3'd2;
    localparam logic [2:0] ANNOUNCE   = 3'd3;
    localparam logic [2:0] STREAM     = 3'd4;
    localparam logic [2:0] SKIP       = 3'd5;

    logic [2:0]    state;
    logic [5:0]    pend_len;
    logic [63:0]   pend_prefix;
    logic [2:0]    pre_cnt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] ptr;
    logic [CW-1:0] ptr_nxt;
    logic          skip_pay;
    logic          accept;
    logic [7:0]    buf_mem [PAYLOAD_BYTES];

    assign rx_ready   = (state != ANNOUNCE) && (state != STREAM);
    assign accept     = rx_valid && rx_ready;
    assign data_ready = (state == ANNOUNCE);
    assign pay_last   = (state == STREAM) && (ptr == LAST);
    assign ptr_nxt    = ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (state == RX_PAYLOAD && accept)
            buf_mem[cnt[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RX_LEN;
            pend_len       <= '0;
            pend_prefix    <= '0;
            pre_cnt        <= '0;
            cnt            <= '0;
            ptr            <= '0;
            skip_pay       <= 1'b0;
            data_in_prefix <= '0;
            data_in_len    <= '0;
            data_in        <= '0;
            err_count      <= '0;
        end else begin
            case (state)
                RX_LEN: if (accept) begin
                    pre_cnt <= '0;
                    cnt     <= '0;
                    if (rx_byte[7:6] == 2'b00) begin
                        pend_len <= rx_byte[5:0];
                        state    <= RX_PREFIX;
                    end else begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        skip_pay <= 1'b0;
                        state    <= SKIP;
                    end
                end
                RX_PREFIX: if (accept) begin
                    pend_prefix <= {pend_prefix[55:0], rx_byte};
                    pre_cnt     <= pre_cnt + 3'd1;
                    if (pre_cnt == 3'd7) state <= RX_PAYLOAD;
                end
                RX_PAYLOAD: if (accept) begin
                    if (cnt == LAST) begin
                        cnt            <= '0;
                        data_in_prefix <= pend_prefix;
                        data_in_len    <= pend_len;
                        state          <= ANNOUNCE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ANNOUNCE: begin
                    ptr     <= '0;
                    data_in <= buf_mem[0];
                    state   <= STREAM;
                end
                STREAM: begin
                    // drop outranks advance; both end the packet with data_in cleared
                    if (pkt_drop || (pay_advance && ptr == LAST)) begin
                        ptr     <= '0;
                        data_in <= '0;
                        state   <= RX_LEN;
                    end else if (pay_advance) begin
                        ptr     <= ptr_nxt;
                        data_in <= buf_mem[ptr_nxt[AW-1:0]];
                    end
                end
                SKIP: if (accept) begin
                    // prefix-length phase first, then payload-length phase
                    if (!skip_pay) begin
                        pre_cnt <= pre_cnt + 3'd1;
                        if (pre_cnt == 3'd7) skip_pay <= 1'b1;
                    end else if (cnt == LAST) begin
                        cnt      <= '0;
                        skip_pay <= 1'b0;
                        state    <= RX_LEN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_LEN;
            endcase
        end
    end
endmodule

// File: tb/tb_ndn_data_ingress.sv
// Directed bench: packet-level model checked every cycle, plus literal pins.
module tb_ndn_data_ingress;
    localparam int P = 16;

    logic        clk, rst, rx_valid, rx_ready, data_ready, pay_advance, pkt_drop, pay_last;
    logic [7:0]  rx_byte, data_in, err_count;
    logic [63:0] data_in_prefix;
    logic [5:0]  data_in_len;

    ndn_data_ingress #(.PAYLOAD_BYTES(P)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
        .data_in_prefix(data_in_prefix), .data_in_len(data_in_len), .data_ready(data_ready),
        .data_in(data_in), .pay_advance(pay_advance), .pkt_drop(pkt_drop),
        .pay_last(pay_last), .err_count(err_count)
    );

    typedef struct packed {
        logic [63:0]    pfx;
        logic [5:0]     len;
        logic [P*8-1:0] pay;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t cur;
    int   n_vec = 0, n_err = 0, cyc = 0, exp_err = 0, idx = 0;
    bit   in_stream = 0, st_next = 0, end_chk = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // packet-level model: every announced packet must match the next queued frame
    always @(negedge clk) begin
        if (rst) begin
            in_stream = 0; st_next = 0; end_chk = 0;
        end else begin
            chk("err_count", err_count, exp_err);
            if (st_next) begin in_stream = 1; idx = 0; st_next = 0; end
            if (end_chk) begin
                chk("data_in_after_end", data_in, 0);
                chk("rx_ready_after_end", rx_ready, 1);
                end_chk = 0;
            end
            if (in_stream) begin
                chk("data_in", data_in, cur.pay[8*idx +: 8]);
                chk("pay_last", pay_last, idx == P-1);
                chk("rx_ready_stream", rx_ready, 0);
                chk("data_ready_stream", data_ready, 0);
                if (pkt_drop) begin in_stream = 0; end_chk = 1; end
                else if (pay_advance) begin
                    if (idx == P-1) begin in_stream = 0; end_chk = 1; end
                    else idx++;
                end
            end else if (data_ready) begin
                if (exp_q.size() == 0) chk("spurious_announce", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    chk("prefix", data_in_prefix, cur.pfx);
                    chk("len", data_in_len, cur.len);
                    chk("rx_ready_announce", rx_ready, 0);
                    st_next = 1;
                end
            end else begin
                chk("rx_ready_idle", rx_ready, 1);
                chk("pay_last_idle", pay_last, 0);
            end
        end
    end

    task automatic send_frame(input logic [7:0] hdr, input logic [63:0] pfx,
                              input logic [7:0] base, input int gap, input bit noise);
        pkt_t p;
        logic [7:0] b;
        pay_advance = noise; pkt_drop = noise;
        for (int i = 0; i < 9 + P; i++) begin
            if (i == 0) b = hdr;
            else if (i < 9) b = pfx[63 - 8*(i-1) -: 8];
            else b = base + 8'(i - 9);
            rx_valid = 1; rx_byte = b;
            @(posedge clk); #1;
            if (i == 0 && hdr[7:6] != 0 && exp_err != 255) exp_err++;
            if (gap > 0 && i < 8 + P) begin
                rx_valid = 0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        rx_valid = 0; pay_advance = 0; pkt_drop = 0;
        if (hdr[7:6] == 0) begin
            p.pfx = pfx; p.len = hdr[5:0];
            for (int j = 0; j < P; j++) p.pay[8*j +: 8] = base + 8'(j);
            exp_q.push_back(p);
        end
    endtask

    // mode 0: advance held; 1: drop+advance at pointer 3; 2: irregular advance
    task automatic consume(input int mode, input logic [7:0] first);
        int k, n;
        k = 0;
        while (!data_ready && k < 200) begin @(posedge clk); #1; k++; end
        if (!data_ready) begin chk("announce_timeout", 0, 1); return; end
        @(posedge clk); #1;
        chk("first_stream_byte", data_in, first);
        if (mode == 0) begin
            pay_advance = 1;
            repeat (P) begin @(posedge clk); #1; end
        end else if (mode == 1) begin
            pay_advance = 1;
            repeat (3) begin @(posedge clk); #1; end
            pkt_drop = 1;
            @(posedge clk); #1;
        end else begin
            n = 0; k = 0;
            while (n < P && k < 200) begin
                pay_advance = (k % 3 != 0);
                @(posedge clk); #1;
                if (pay_advance) n++;
                k++;
            end
        end
        pay_advance = 0; pkt_drop = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        logic [63:0] pa;
        pa = 64'h0102030405060708;
        rst = 1; rx_valid = 0; rx_byte = 0; pay_advance = 0; pkt_drop = 0;
        #2;
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_prefix", data_in_prefix, 0);
        chk("rst_err", err_count, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // basic frame, no idle cycles
        t0 = cyc;
        send_frame(8'h10, pa, 8'hA0, 0, 0);
        chk("lat_nogap", cyc - t0, 25);
        chk("lit_data_ready", data_ready, 1);
        chk("lit_prefix", data_in_prefix, 64'h0102030405060708);
        chk("lit_len", data_in_len, 16);
        consume(0, 8'hA0);

        // malformed header, then a good frame with controls toggling during receive
        send_frame(8'hC5, 64'h1111111111111111, 8'h00, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("lit_err1", err_count, 1);
        chk("lit_no_announce", data_ready, 0);
        send_frame(8'h05, 64'hA1B2C3D4E5F60718, 8'h30, 0, 1);
        consume(2, 8'h30);

        // drop with simultaneous advance at pointer 3
        send_frame(8'h3F, 64'hDEADBEEFCAFEF00D, 8'h50, 0, 0);
        consume(1, 8'h50);
        chk("lit_drop_data_in", data_in, 0);
        chk("lit_drop_prefix", data_in_prefix, 64'hDEADBEEFCAFEF00D);
        chk("lit_drop_len", data_in_len, 6'h3F);
        chk("lit_drop_rx_ready", rx_ready, 1);

        // rx_valid toggling: one idle cycle between every accepted byte
        t0 = cyc;
        send_frame(8'h10, pa, 8'hA0, 1, 0);
        chk("lat_gap", cyc - t0, 25 + 24);
        chk("lit_gap_prefix", data_in_prefix, 64'h0102030405060708);
        consume(0, 8'hA0);

        // reset while prefix byte 5 is on the wire
        rx_valid = 1; rx_byte = 8'h08; @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin rx_byte = 8'h90 + 8'(i); @(posedge clk); #1; end
        rx_byte = 8'h94;
        rst = 1; exp_err = 0;
        #1;
        chk("mid_rst_prefix", data_in_prefix, 0);
        chk("mid_rst_len", data_in_len, 0);
        chk("mid_rst_data_in", data_in, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_rx_ready", rx_ready, 1);
        chk("mid_rst_data_ready", data_ready, 0);
        rx_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        send_frame(8'h22, 64'h8877665544332211, 8'hC0, 0, 0);
        chk("lit_post_rst_prefix", data_in_prefix, 64'h8877665544332211);
        consume(0, 8'hC0);

        // error counter saturation
        for (int i = 0; i < 256; i++) send_frame(8'h40 | 8'(i & 8'h3F) | 8'(i[7] << 7), 64'h0, 8'h00, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        chk("lit_err_sat", err_count, 255);
        chk("lit_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
